// File: rtl/spi_pkg.sv
// spi_pkg: FSM states, SPI mode constants and default word width shared by spi_main and spi_sub
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam int DATA_OUT_DEF = 128;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter; tick marks the last clk cycle of each sclk half-period
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (rst || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_main.sv
// spi_main: SPI main, MSB first, sclk idle low; data launched on sclk rise, sampled on sclk fall
module spi_main import spi_pkg::*; #(
  parameter int DATA_OUT = DATA_OUT_DEF,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_OUT-1:0] tx,
  output logic [DATA_OUT-1:0] rx,
  output logic                busy,
  output logic                done,
  output logic                cs,
  output logic                sclk,
  output logic                sdo,
  input  logic                sdi
);
  localparam int BW = $clog2(DATA_OUT + 1);
  state_t state, state_n;
  logic [DATA_OUT-1:0] tx_sr, tx_sr_n, rx_sr, rx_sr_n, rx_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic cs_n, sclk_n, busy_n, done_n, tick, launch;
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (.clk, .rst, .en(state != IDLE), .tick);
  assign launch = (sclk == CPOL) ^ CPHA;
  assign sdo = tx_sr[DATA_OUT-1];
  always_comb begin
    state_n = state;
    cs_n = cs;
    sclk_n = sclk;
    busy_n = busy;
    done_n = 1'b0;
    tx_sr_n = tx_sr;
    rx_sr_n = rx_sr;
    rx_n = rx;
    bit_n = bit_cnt;
    case (state)
      IDLE: if (start && !done) begin
        state_n = SETUP;
        cs_n = 1'b0;
        busy_n = 1'b1;
        tx_sr_n = tx;
        rx_sr_n = '0;
        bit_n = '0;
      end
      SETUP: if (tick) begin
        state_n = SHIFT;
        sclk_n = ~CPOL;
      end
      SHIFT: if (tick) begin
        sclk_n = ~sclk;
        if (launch) tx_sr_n = tx_sr << 1;
        else begin
          rx_sr_n = {rx_sr[DATA_OUT-2:0], sdi};
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == BW'(DATA_OUT - 1)) state_n = HOLD;
        end
      end
      HOLD: if (tick) begin
        state_n = IDLE;
        cs_n = 1'b1;
        busy_n = 1'b0;
        done_n = 1'b1;
        rx_n = rx_sr;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cs <= 1'b1;
      sclk <= CPOL;
      busy <= 1'b0;
      done <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
      rx <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_n;
      cs <= cs_n;
      sclk <= sclk_n;
      busy <= busy_n;
      done <= done_n;
      tx_sr <= tx_sr_n;
      rx_sr <= rx_sr_n;
      rx <= rx_n;
      bit_cnt <= bit_n;
    end
  end
endmodule

// File: doc/spi_main.md
SPI_MAIN -- requirements
Module: spi_main

Interface
REQ-001 Parameter DATA_OUT, default 128: bits per transfer, MSB first.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per sclk half-period; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  transfer request; sampled only while busy=0.
REQ-006 tx  input  DATA_OUT  word to send (e.g. AES ciphertext/key); captured on accepted start.
REQ-007 rx  output  DATA_OUT  last complete word received from the subordinate.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-009 done  output  1  one-cycle pulse; transfer complete, rx valid.
REQ-010 cs  output  1  active-low chip select to the subordinate.
REQ-011 sclk  output  1  serial clock, idle low (CPOL=0).
REQ-012 sdo  output  1  main-out data to the subordinate's sdi.
REQ-013 sdi  input  1  subordinate-out data from the subordinate's sdo.

Function
REQ-014 States: IDLE, SETUP, SHIFT, HOLD; all outputs registered.
REQ-015 IDLE: cs=1, sclk=0, busy=0; start=1 captures tx into the shift register, sets cs=0, drives sdo=tx[DATA_OUT-1], sets busy=1, and moves to SETUP.
REQ-016 start while busy=1 is ignored; tx changes after capture have no effect.
REQ-017 A half-period counter counts 0..CLK_DIV-1; every sclk toggle and every state change out of SETUP/HOLD happens when it wraps.
REQ-018 SETUP: sclk held low for CLK_DIV cycles, then sclk=1 and move to SHIFT.
REQ-019 SHIFT: sclk toggles every CLK_DIV cycles, giving DATA_OUT full periods.
REQ-020 On each sclk falling edge, sdi is shifted into the rx shift-register LSB and the bit counter increments.
REQ-021 On each sclk rising edge except the first, sdo advances to the next lower tx bit. sdo is therefore stable across every falling edge, where the subordinate samples.
REQ-022 When the bit counter reaches DATA_OUT at a falling edge, sclk stays low and the FSM moves to HOLD.
REQ-023 HOLD lasts CLK_DIV cycles. It then completes in one cycle: cs=1, rx loaded from the shift register, done=1 for one cycle, busy=0, return to IDLE.
REQ-024 Timing: accepted start in cycle 0 gives cs low at cycle 1. Rising edge k (k=0..DATA_OUT-1) occurs at cycle 1+CLK_DIV*(2k+1); falling edge k at cycle 1+CLK_DIV*(2k+2). done occurs at cycle 1+CLK_DIV*(2*DATA_OUT+1).
REQ-025 start=1 in the same cycle done=1 is not accepted; a new start is accepted no earlier than the following cycle (minimum cs-high time is one clk).
REQ-026 The bit counter is clog2(DATA_OUT+1) bits wide and never wraps; rx changes only at done.

Reset
REQ-027 rst=1 at any time, including mid-transfer, forces the following on the next clk edge: state IDLE, cs=1, sclk=0, sdo=0, busy=0, done=0, rx=0, and all counters and shift registers to 0.
REQ-028 An aborted transfer produces no done pulse, and rx keeps its reset value.

Structure
REQ-029 Package spi_pkg holds the FSM state enumeration, CPOL/CPHA constants, and the default DATA_OUT value shared with spi_sub.
REQ-030 The half-period counter and sclk toggle logic live in one sub-module, spi_clk_div, with ports clk, rst, en, tick. spi_main contains the FSM and the shift registers.

Verification
REQ-031 DATA_OUT=8, CLK_DIV=2, sdi tied to sdo, tx=8'hA5, start at cycle 0 -> cs low at cycle 1, 8 sclk periods, done at cycle 35, rx=8'hA5.
REQ-032 DATA_OUT=8, CLK_DIV=1, sdi driven by a model shifting 8'h3C on sclk rising edges -> rx=8'h3C, done at cycle 18, mosi bits observed at falling edges = tx MSB-first.
REQ-033 Default parameters with spi_sub attached, tx=128'h00112233445566778899aabbccddeeff and spi_sub tx=128'h69c4e0d86a7b0430d8cdb78070b4c55a -> spi_sub rx equals main tx; main rx equals 128'h69c4...c55a.
REQ-034 start pulsed again at cycles 5 and 20 of a CLK_DIV=2, DATA_OUT=8 transfer -> ignored; exactly one done, at cycle 35.
REQ-035 rst asserted at cycle 12 of the REQ-031 transfer -> cs=1, sclk=0, busy=0 at cycle 13; no done; a fresh start then completes normally with rx=8'hA5.
REQ-036 start held high continuously -> transfers repeat back-to-back, with cs high for exactly one cycle between consecutive done pulses and the next cs fall.
